fifo_sync_level: RTL and testbench
==================================

// Module: fifo_sync_level
//
// PURPOSE
//  Single-clock, parametrised FIFO. It is the synchronous successor to the
//  pointer-ring FIFO used for clock crossings. It supports any depth
//  (not only powers of two) and provides an occupancy count, programmable
//  almost-full/almost-empty flags and a synchronous flush. It sits between
//  same-clock producer/consumer pairs: bus adapters, DMA staging, UART buffers.
//
// PARAMETERS
//  data_size     8   payload width in bits, >=1
//  buffer_size   8   number of entries, >=1, any integer
//  afull_thr     6   almost_full asserted when count >= afull_thr (1..buffer_size)
//  aempty_thr    1   almost_empty asserted when count <= aempty_thr (0..buffer_size-1)
//  cnt_w = $clog2(buffer_size+1)  (localparam, count width)
//
// PORTS
//  clk           in   1          single clock, all logic on posedge
//  rst           in   1          synchronous reset, active-high
//  enq_data      in   data_size  write payload
//  enq_valid     in   1          producer offers enq_data
//  enq_ready     out  1          FIFO can accept; push = enq_valid & enq_ready
//  deq_data      out  data_size  head entry, '0 while empty
//  deq_valid     out  1          head entry valid; pop = deq_valid & deq_ready
//  deq_ready     in   1          consumer takes head
//  flush         in   1          synchronous discard of all contents
//  count         out  cnt_w      current occupancy, 0..buffer_size
//  full          out  1          count == buffer_size
//  empty         out  1          count == 0
//  almost_full   out  1          count >= afull_thr
//  almost_empty  out  1          count <= aempty_thr
//
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0.
//    Outputs after reset: empty=1, full=0, almost_empty=1, almost_full=0,
//    enq_ready=1, deq_valid=0, deq_data='0. Memory is not reset.
//  - Reset overrides flush, push and pop. Mid-operation reset drops all contents.
//  - Pointers are binary 0..buffer_size-1 and wrap from buffer_size-1 to 0.
//    No power-of-two assumption; buffer_size=1 uses a single entry with 1-bit count.
//  - enq_ready = !full & !flush; deq_valid = !empty & !flush. Both are combinational from state.
//  - deq_data = mem[rd_ptr], read combinationally (show-ahead). Latency: push at
//    edge N -> deq_valid=1 and data visible after edge N.
//  - count update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
//    full, empty, almost_full and almost_empty derive combinationally from count.
//  - Full: enq_ready=0 even if pop this cycle (no write-through). The pop proceeds, and
//    enq_ready returns the next cycle.
//  - Empty: deq_valid=0 and no bypass. A push this cycle is readable next cycle.
//  - Simultaneous push+pop when neither full nor empty: both pointers advance and
//    count holds.
//  - flush=1: handshakes suppressed that cycle (ready/valid forced 0). At the edge
//    wr_ptr=rd_ptr=count=0. Data in flight that cycle is discarded.
//  - Protocol: deq_data is stable while deq_valid=1 and no pop.
//    enq_valid may drop without a push.
//
// CONFIGURATION
//  FIFO_SYNC_PEAK_EN defined: adds output port peak_count [cnt_w], a high-water mark.
//  - peak_count <= max(peak_count, next count) every cycle.
//  - Cleared to 0 by rst or flush.
//  Undefined: port and register absent; all other behaviour identical.
//
// TESTING  (data_size=8, buffer_size=6, afull_thr=5, aempty_thr=1)
//  1. Reset, then idle
//     -> empty=1, almost_empty=1, count=0, enq_ready=1, deq_valid=0, deq_data=0.
//  2. Push 0x11..0x16 with deq_ready=0
//     -> almost_full at count=5; full=1 and enq_ready=0 at count=6.
//     -> 7th push is held off, count stays 6.
//  3. From full, pop with enq_valid held
//     -> pop cycle enq_ready=0, next cycle enq_ready=1.
//     -> Drain yields 0x11..0x16 in order.
//  4. Continuous push+pop for 20 cycles at count=3
//     -> count stays 3, pointers wrap (5->0), data order preserved.
//  5. Flush at count=4 with enq_valid=deq_valid=1
//     -> no push/pop that cycle; next cycle count=0, empty=1.
//     -> peak_count=0 if FIFO_SYNC_PEAK_EN.
//  6. Assert rst with count=4 and a push pending
//     -> next cycle count=0, empty=1; the pushed word is not later read.
//  7. FIFO_SYNC_PEAK_EN: fill to 4, drain to 0
//     -> peak_count=4 persists until flush/rst.

Source files
------------

// File: rtl/fifo_sync_level.sv
// fifo_sync_level: single-clock FIFO of any depth, with show-ahead read,
// occupancy count, programmable almost-full/almost-empty flags and a
// synchronous flush.
// Optional feature: define FIFO_SYNC_PEAK_EN to add the peak_count output,
// a high-water mark of the occupancy that rst and flush clear.
//
// Handshake: a word moves only on a clock edge where valid and ready are both
// high (push = enq_valid & enq_ready, pop = deq_valid & deq_ready). Ready and
// valid come from registered state and flush only, never from the partner's
// valid or ready. deq_data holds steady while deq_valid=1 and no pop occurs.
module fifo_sync_level #(
    parameter int data_size   = 8,
    parameter int buffer_size = 8,
    parameter int afull_thr   = 6,
    parameter int aempty_thr  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [data_size-1:0]               enq_data,
    input  logic                               enq_valid,
    output logic                               enq_ready,
    output logic [data_size-1:0]               deq_data,
    output logic                               deq_valid,
    input  logic                               deq_ready,
    input  logic                               flush,
    output logic [$clog2(buffer_size+1)-1:0]   count,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
`ifdef FIFO_SYNC_PEAK_EN
    output logic                               almost_empty,
    output logic [$clog2(buffer_size+1)-1:0]   peak_count
`else
    output logic                               almost_empty
`endif
);
    localparam int cnt_w = $clog2(buffer_size + 1);
    localparam int ptr_w = (buffer_size > 1) ? $clog2(buffer_size) : 1;

    localparam logic [ptr_w-1:0] c_last_ptr   = ptr_w'(buffer_size - 1);
    localparam logic [cnt_w-1:0] c_depth      = cnt_w'(buffer_size);
    localparam logic [cnt_w-1:0] c_afull_thr  = cnt_w'(afull_thr);
    localparam logic [cnt_w-1:0] c_aempty_thr = cnt_w'(aempty_thr);

    logic [data_size-1:0] r_mem [buffer_size];
    logic [ptr_w-1:0]     r_wr_ptr;
    logic [ptr_w-1:0]     r_rd_ptr;
    logic [cnt_w-1:0]     r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [cnt_w-1:0]     w_count_nxt;
    logic [ptr_w-1:0]     w_wr_ptr_inc;
    logic [ptr_w-1:0]     w_rd_ptr_inc;

    // Status flags and handshakes, all decoded from the occupancy count.
    always_comb begin
        w_full       = (r_count == c_depth);
        w_empty      = (r_count == '0);
        enq_ready    = !w_full && !flush;
        deq_valid    = !w_empty && !flush;
        w_push       = enq_valid && enq_ready;
        w_pop        = deq_valid && deq_ready;
        full         = w_full;
        empty        = w_empty;
        almost_full  = (r_count >= c_afull_thr);
        almost_empty = (r_count <= c_aempty_thr);
        count        = r_count;
        // Show-ahead head; zero when there is nothing to show.
        deq_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    end

    // Pointer increments wrap at the last entry, so depth need not be a power of two.
    always_comb begin
        w_wr_ptr_inc = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_inc = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
    end

    // Next occupancy: push and pop in the same cycle cancel out; flush empties.
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Pointer and count state; reset takes priority over flush, which wins over traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= w_count_nxt;
        end
    end

    // Storage write; contents are not reset, stale words are masked by the count.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= enq_data;
        end
    end

`ifdef FIFO_SYNC_PEAK_EN
    logic [cnt_w-1:0] r_peak;

    // High-water mark of the occupancy, tracked against the upcoming count.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_peak <= '0;
        end else if (w_count_nxt > r_peak) begin
            r_peak <= w_count_nxt;
        end
    end

    assign peak_count = r_peak;
`endif

endmodule

// File: tb/tb_fifo_sync_level.sv
// Testbench for fifo_sync_level (data_size=8, buffer_size=6, afull_thr=5,
// aempty_thr=1). A queue-based reference model predicts every output each
// cycle; directed scenarios are followed by a randomized phase.
// Build with FIFO_SYNC_PEAK_EN defined to also cover peak_count.
`timescale 1ns/1ps
module tb_fifo_sync_level;
    localparam int DW    = 8;
    localparam int DEPTH = 6;
    localparam int AFULL = 5;
    localparam int AEMPT = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] enq_data;
    logic          enq_valid;
    logic          enq_ready;
    logic [DW-1:0] deq_data;
    logic          deq_valid;
    logic          deq_ready;
    logic          flush;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
`ifdef FIFO_SYNC_PEAK_EN
    logic [CW-1:0] peak_count;
`endif

    // Scoreboard: expected FIFO contents, head at index 0.
    logic [DW-1:0] exp_q[$];
    int            exp_peak;
    int            n_checks;
    int            n_pass;

    fifo_sync_level #(
        .data_size  (DW),
        .buffer_size(DEPTH),
        .afull_thr  (AFULL),
        .aempty_thr (AEMPT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enq_data    (enq_data),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .deq_data    (deq_data),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .flush       (flush),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
`ifdef FIFO_SYNC_PEAK_EN
        .almost_empty(almost_empty),
        .peak_count  (peak_count)
`else
        .almost_empty(almost_empty)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs
    // against the model, then advance the model across the rising edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r,
                         input logic fl, input logic rs);
        int  sz;
        bit  e_ready, e_valid, do_push, do_pop;
        @(negedge clk);
        enq_valid = v;
        enq_data  = d;
        deq_ready = r;
        flush     = fl;
        rst       = rs;
        #1;
        sz      = exp_q.size();
        e_ready = (sz < DEPTH) && !fl;
        e_valid = (sz > 0) && !fl;
        do_push = v && e_ready;
        do_pop  = r && e_valid;
        check("count",        int'(count),        sz);
        check("full",         int'(full),         int'(sz == DEPTH));
        check("empty",        int'(empty),        int'(sz == 0));
        check("almost_full",  int'(almost_full),  int'(sz >= AFULL));
        check("almost_empty", int'(almost_empty), int'(sz <= AEMPT));
        check("enq_ready",    int'(enq_ready),    int'(e_ready));
        check("deq_valid",    int'(deq_valid),    int'(e_valid));
        check("deq_data",     int'(deq_data),     (sz > 0) ? int'(exp_q[0]) : 0);
`ifdef FIFO_SYNC_PEAK_EN
        check("peak_count",   int'(peak_count),   exp_peak);
`endif
        @(posedge clk);
        if (rs || fl) begin
            exp_q.delete();
            exp_peak = 0;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(d);
            if (exp_q.size() > exp_peak) exp_peak = exp_q.size();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        exp_peak  = 0;
        enq_valid = 1'b0;
        enq_data  = '0;
        deq_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        // Reset: two cycles with rst high, then idle checks reset state.
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Fill 0x11..0x16, then a 7th push is held off.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h11 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);

        // From full: pop with enq_valid held (enq_ready returns next cycle).
        cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        // Drain everything in order.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Reach count=3, then 20 cycles of simultaneous push+pop.
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, DW'(8'h40 + i), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Go to count=4, then flush with both handshakes offered.
        cycle(1'b1, 8'h50, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
        idle(1);

        // count=4 with a push pending when rst rises; pushed word must vanish.
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Peak: fill to 4, drain to 0, peak persists; then flush clears it.
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(3);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 99) < 60),
                  DW'($urandom_range(0, 255)),
                  1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 99) < 2),
                  1'($urandom_range(0, 199) < 1));
        end
        // Final drain.
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
